// File: rtl/branch_predictor_pkg.sv
// Shared encodings and helpers for the 2-bit saturating-counter branch predictor.
package branch_pred_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat2_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    nxt = state;
    if (taken) begin
      if (state != ST) nxt = state + 2'd1;
    end else begin
      if (state != SNT) nxt = state - 2'd1;
    end
    return nxt;
  endfunction

  // Word-aligned PC; callers truncate to their index width.
  function automatic logic [31:0] bht_idx(input logic [31:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and ID-resolve signals between the pipeline (master) and the predictor (slave).
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic              id_valid;
  logic              id_stall;
  logic [ADDR_W-1:0] id_pc;
  logic              id_pred_taken;
  logic              id_taken;
  logic [ADDR_W-1:0] id_target;
  logic              flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output if_pc, id_valid, id_stall, id_pc, id_pred_taken, id_taken, id_target,
    input  pred_taken, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  if_pc, id_valid, id_stall, id_pc, id_pred_taken, id_taken, id_target,
    output pred_taken, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// One BHT entry: a 2-bit saturating counter trained when en_i is high.
module sat_counter2
  import branch_pred_pkg::*;
#(
  parameter logic [1:0] INIT_STATE = WNT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       taken_i,
  output logic [1:0] state_o
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  assign state_d = en_i ? sat2_next(state_q, taken_i) : state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= INIT_STATE;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/branch_predictor.sv
// Tagless BHT predictor: combinational IF lookup, ID-stage training, mispredict redirect and statistics.
module branch_predictor
  import branch_pred_pkg::*;
#(
  parameter int         IDX_W      = 4,
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] INIT_STATE = WNT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  branch_predictor_if.slave   bus,
  output logic [31:0]         branch_cnt_o,
  output logic [31:0]         mispred_cnt_o
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;
  logic [1:0]       bht_state [ENTRIES];
  logic             resolve;
  logic             mispredict;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;

  assign if_idx = IDX_W'(bht_idx(32'(bus.if_pc)));
  assign id_idx = IDX_W'(bht_idx(32'(bus.id_pc)));

  assign resolve    = bus.id_valid & ~bus.id_stall & start_i & ~rst_i;
  assign mispredict = resolve & (bus.id_pred_taken != bus.id_taken);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_bht
    sat_counter2 #(
      .INIT_STATE (INIT_STATE)
    ) u_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (resolve && (id_idx == IDX_W'(g))),
      .taken_i (bus.id_taken),
      .state_o (bht_state[g])
    );
  end

  // Reads the pre-edge counter, so a same-cycle update is not bypassed.
  assign bus.pred_taken = start_i & ~rst_i & bht_state[if_idx][1];

  assign bus.flush          = mispredict;
  assign bus.redirect_valid = mispredict;
  assign bus.redirect_pc    = !mispredict ? '0 :
                              bus.id_taken ? bus.id_target : bus.id_pc + ADDR_W'(4);

  assign branch_cnt_d  = (resolve && branch_cnt_q != 32'hFFFF_FFFF)
                         ? branch_cnt_q + 32'd1 : branch_cnt_q;
  assign mispred_cnt_d = (mispredict && mispred_cnt_q != 32'hFFFF_FFFF)
                         ? mispred_cnt_q + 32'd1 : mispred_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;
  int          total;
  int          bad;

  branch_predictor_if #(.ADDR_W(32)) bus ();

  branch_predictor #(.IDX_W(4), .ADDR_W(32), .INIT_STATE(2'b01)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .bus           (bus),
    .branch_cnt_o  (branch_cnt),
    .mispred_cnt_o (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic stall, input logic [31:0] pc,
                          input logic pt, input logic tk, input logic [31:0] tgt);
    bus.id_valid      = v;
    bus.id_stall      = stall;
    bus.id_pc         = pc;
    bus.id_pred_taken = pt;
    bus.id_taken      = tk;
    bus.id_target     = tgt;
    #1;
  endtask

  task automatic check_out(input string name, input logic pred, input logic fl,
                           input logic [31:0] rpc);
    total++;
    if (bus.pred_taken !== pred) begin
      bad++; $display("FAIL %s pred_taken got=%b exp=%b", name, bus.pred_taken, pred);
    end
    total++;
    if (bus.flush !== fl || bus.redirect_valid !== fl) begin
      bad++; $display("FAIL %s flush/redirect_valid got=%b/%b exp=%b", name, bus.flush, bus.redirect_valid, fl);
    end
    total++;
    if (bus.redirect_pc !== rpc) begin
      bad++; $display("FAIL %s redirect_pc got=%h exp=%h", name, bus.redirect_pc, rpc);
    end
  endtask

  task automatic check_cnt(input string name, input logic [31:0] b, input logic [31:0] m);
    total++;
    if (branch_cnt !== b || mispred_cnt !== m) begin
      bad++; $display("FAIL %s counts got=%0d/%0d exp=%0d/%0d", name, branch_cnt, mispred_cnt, b, m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.if_pc = 32'h10;
    drive_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    check_out("reset_out", 1'b0, 1'b0, 32'h0);
    check_cnt("reset_cnt", 32'd0, 32'd0);
    rst = 1'b0; start = 1'b1; #1;
    check_out("post_reset_lookup", 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_train_taken();
    logic [2:0] exp_pred;
    logic [2:0] exp_flush;
    exp_pred  = 3'b110;   // bit i: prediction before resolve i (01,10,11)
    exp_flush = 3'b001;
    for (int i = 0; i < 3; i++) begin
      bus.if_pc = 32'h10;
      drive_id(1'b1, 1'b0, 32'h10, exp_pred[i], 1'b1, 32'h80);
      check_out($sformatf("train_taken_%0d", i), exp_pred[i], exp_flush[i],
                exp_flush[i] ? 32'h80 : 32'h0);
      tick();
    end
    drive_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_out("train_taken_after", 1'b1, 1'b0, 32'h0);
    check_cnt("train_taken_cnt", 32'd3, 32'd1);
  endtask

  task automatic test_redirect();
    drive_id(1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 32'h40);
    check_out("redirect_nt", 1'b1, 1'b1, 32'h24);
    tick();
    drive_id(1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 32'h40);
    check_out("redirect_t", 1'b1, 1'b1, 32'h40);
    tick();
    drive_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_cnt("redirect_cnt", 32'd5, 32'd3);
  endtask

  task automatic test_stall();
    bus.if_pc = 32'h30;
    for (int i = 0; i < 2; i++) begin
      drive_id(1'b1, 1'b1, 32'h30, 1'b0, 1'b1, 32'h100);
      check_out($sformatf("stall_%0d", i), 1'b0, 1'b0, 32'h0);
      tick();
      check_cnt($sformatf("stall_cnt_%0d", i), 32'd5, 32'd3);
    end
    drive_id(1'b1, 1'b0, 32'h30, 1'b0, 1'b1, 32'h100);
    check_out("stall_release", 1'b0, 1'b1, 32'h100);
    tick();
    drive_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_out("stall_trained", 1'b1, 1'b0, 32'h0);
    tick();
    check_cnt("stall_once", 32'd6, 32'd4);
  endtask

  task automatic test_same_cycle_alias();
    bus.if_pc = 32'h10;
    drive_id(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0);
    check_out("alias_dec1", 1'b1, 1'b1, 32'h14);
    tick();
    bus.if_pc = 32'h50;
    drive_id(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0);
    check_out("alias_dec2_old", 1'b1, 1'b1, 32'h14);
    tick();
    drive_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_out("alias_dec2_new", 1'b0, 1'b0, 32'h0);
    drive_id(1'b1, 1'b0, 32'h50, 1'b0, 1'b1, 32'h90);
    check_out("same_cycle_old", 1'b0, 1'b1, 32'h90);
    tick();
    drive_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus.if_pc = 32'h10; #1;
    check_out("same_cycle_new_alias", 1'b1, 1'b0, 32'h0);
    check_cnt("alias_cnt", 32'd9, 32'd7);
  endtask

  task automatic test_start_and_midreset();
    start = 1'b0;
    drive_id(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0);
    check_out("stopped", 1'b0, 1'b0, 32'h0);
    tick();
    check_cnt("stopped_cnt", 32'd9, 32'd7);
    start = 1'b1; drive_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_out("stopped_held", 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    drive_id(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0);
    check_out("midreset", 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    drive_id(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_cnt("midreset_cnt", 32'd0, 32'd0);
    check_out("midreset_idx4", 1'b0, 1'b0, 32'h0);
    bus.if_pc = 32'h30; #1;
    check_out("midreset_idx12", 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_train_taken();
    test_redirect();
    test_stall();
    test_same_cycle_alias();
    test_start_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
